// File: rtl/proc_vec_pkg.sv
// Shared widths, FSM encoding and vector-length helper for the vector memory stage.
package proc_vec_pkg;

    localparam int unsigned DW    = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned IW    = 8;
    localparam int unsigned RW    = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A zero length still moves one row; anything past the hardware maximum is cut back.
    function automatic int unsigned clamp_vlen(input int unsigned vlen, input int unsigned max_vl);
        if (vlen == 0) begin
            return 1;
        end
        if (vlen > max_vl) begin
            return max_vl;
        end
        return vlen;
    endfunction

endpackage

// File: rtl/mem_vec_ram.sv
// Single-port synchronous row RAM with registered read data; drop-in spot for a vendor macro.
module mem_vec_ram #(
    parameter  int unsigned WIDTH = 128,
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Contents and read register are deliberately left out of reset, like a hard macro.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/etapa_mem_vec.sv
// Vector memory stage: issues one RAM row per beat for scalar/vector loads and stores
// and registers one write-back beat per issued row.
module etapa_mem_vec #(
    parameter  int unsigned DW     = proc_vec_pkg::DW,
    parameter  int unsigned LANES  = proc_vec_pkg::LANES,
    parameter  int unsigned DEPTH  = 256,
    parameter  int unsigned MAX_VL = 8,
    parameter  int unsigned IW     = proc_vec_pkg::IW,
    parameter  int unsigned RW     = proc_vec_pkg::RW,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned VLW    = $clog2(MAX_VL + 1),
    localparam int unsigned WW     = LANES * DW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           valid_in,
    output logic           ready_out,
    input  logic           mem_rd,
    input  logic           mem_wr,
    input  logic           vec_op,
    input  logic [VLW-1:0] vlen,
    input  logic [AW-1:0]  addr_in,
    input  logic [WW-1:0]  data_in,
    input  logic [WW-1:0]  result_alu,
    input  logic           sel_data,
    input  logic [RW-1:0]  dir_dest_in,
    input  logic [IW-1:0]  inmediate_in,
    output logic           valid_out,
    output logic           wb_en,
    output logic [WW-1:0]  mem_out,
    output logic [WW-1:0]  data_out,
    output logic [RW-1:0]  dir_dest_out,
    output logic [IW-1:0]  inmediate_out,
    output logic [VLW-1:0] beat_idx,
    output logic           last_out
);

    import proc_vec_pkg::*;

    // Handshake: an op transfers on a rising edge where valid_in && ready_out; ready_out
    // depends only on the state register, and once accepted the op runs to completion
    // (data_in is consumed every beat) with no back-pressure from write-back.

    state_t         r_state;
    state_t         w_state_nxt;
    logic [VLW-1:0] r_beat;
    logic [VLW-1:0] w_beat_nxt;

    logic [AW-1:0]  r_base;
    logic [VLW-1:0] r_vl;
    logic           r_rd;
    logic           r_wr;
    logic           r_sel;
    logic [RW-1:0]  r_dest_cap;
    logic [IW-1:0]  r_imm_cap;

    logic           w_accept;
    logic [VLW-1:0] w_eff_vl;
    logic           w_issue;
    logic [AW-1:0]  w_cur_addr;
    logic [VLW-1:0] w_cur_idx;
    logic [VLW-1:0] w_cur_vl;
    logic           w_cur_rd;
    logic           w_cur_wr;
    logic           w_cur_sel;
    logic [RW-1:0]  w_cur_dest;
    logic [IW-1:0]  w_cur_imm;

    logic           w_ram_we;
    logic           w_ram_re;
    logic [WW-1:0]  w_ram_rdata;

    logic           r_valid;
    logic           r_wb_en;
    logic           r_out_load;
    logic           r_out_sel;
    logic [WW-1:0]  r_alu;
    logic [RW-1:0]  r_dest_out;
    logic [IW-1:0]  r_imm_out;
    logic [VLW-1:0] r_idx;
    logic           r_last;

    assign ready_out = (r_state == IDLE);
    assign w_accept  = valid_in && ready_out;

    // Only vector memory ops run more than one beat.
    assign w_eff_vl = (vec_op && (mem_rd || mem_wr))
                    ? VLW'(clamp_vlen(32'(vlen), MAX_VL))
                    : VLW'(1);

    // Beat 0 issues straight from the execute inputs; later beats replay the captured op.
    always_comb begin
        w_issue    = 1'b0;
        w_cur_addr = addr_in;
        w_cur_idx  = '0;
        w_cur_vl   = w_eff_vl;
        w_cur_rd   = mem_rd;
        w_cur_wr   = mem_wr;
        w_cur_sel  = sel_data;
        w_cur_dest = dir_dest_in;
        w_cur_imm  = inmediate_in;
        if (r_state == BUSY) begin
            w_issue    = 1'b1;
            w_cur_addr = r_base + AW'(r_beat);
            w_cur_idx  = r_beat;
            w_cur_vl   = r_vl;
            w_cur_rd   = r_rd;
            w_cur_wr   = r_wr;
            w_cur_sel  = r_sel;
            w_cur_dest = r_dest_cap;
            w_cur_imm  = r_imm_cap;
        end else begin
            w_issue = w_accept;
        end
        if (!rst_n) begin
            w_issue = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        case (r_state)
            IDLE: begin
                if (w_accept && (w_eff_vl > VLW'(1))) begin
                    w_state_nxt = BUSY;
                    w_beat_nxt  = VLW'(1);
                end
            end
            BUSY: begin
                if (r_beat == r_vl - VLW'(1)) begin
                    w_state_nxt = IDLE;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt = r_beat + VLW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_vl       <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_sel      <= 1'b0;
            r_dest_cap <= '0;
            r_imm_cap  <= '0;
        end else if (w_accept) begin
            r_base     <= addr_in;
            r_vl       <= w_eff_vl;
            r_rd       <= mem_rd;
            r_wr       <= mem_wr;
            r_sel      <= sel_data;
            r_dest_cap <= dir_dest_in;
            r_imm_cap  <= inmediate_in;
        end
    end

    // A combined read+write behaves as a store, so the read port stays quiet.
    assign w_ram_we = w_issue && w_cur_wr;
    assign w_ram_re = w_issue && w_cur_rd && !w_cur_wr;

    mem_vec_ram #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_cur_addr),
        .i_wdata (data_in),
        .o_rdata (w_ram_rdata)
    );

    // Write-back side fields only move on an issued beat, so idle cycles hold them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_wb_en    <= 1'b0;
            r_out_load <= 1'b0;
            r_out_sel  <= 1'b0;
            r_alu      <= '0;
            r_dest_out <= '0;
            r_imm_out  <= '0;
            r_idx      <= '0;
            r_last     <= 1'b0;
        end else begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_wb_en    <= !w_cur_wr;
                r_out_load <= w_cur_rd && !w_cur_wr;
                r_out_sel  <= w_cur_sel;
                r_alu      <= result_alu;
                r_dest_out <= w_cur_dest;
                r_imm_out  <= w_cur_imm;
                r_idx      <= w_cur_idx;
                r_last     <= (w_cur_idx == w_cur_vl - VLW'(1));
            end
        end
    end

    // The RAM read register only updates on loads, so gating it keeps stores/ALU beats at 0.
    assign mem_out       = r_out_load ? w_ram_rdata : '0;
    assign data_out      = r_out_sel ? mem_out : r_alu;
    assign valid_out     = r_valid;
    assign wb_en         = r_wb_en;
    assign dir_dest_out  = r_dest_out;
    assign inmediate_out = r_imm_out;
    assign beat_idx      = r_idx;
    assign last_out      = r_last;

endmodule

// File: tb/tb_etapa_mem_vec.sv
// Directed bench for etapa_mem_vec: scoreboard of expected write-back beats built from a row model.
module tb_etapa_mem_vec;

  localparam int W = 128;

  typedef struct packed {
    logic [W-1:0] data;
    logic [W-1:0] mem;
    logic         wb;
    logic [3:0]   idx;
    logic         last;
    logic [2:0]   dest;
    logic [7:0]   imm;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic         valid_in;
  logic         ready_out;
  logic         mem_rd;
  logic         mem_wr;
  logic         vec_op;
  logic [3:0]   vlen;
  logic [7:0]   addr_in;
  logic [W-1:0] data_in;
  logic [W-1:0] result_alu;
  logic         sel_data;
  logic [2:0]   dir_dest_in;
  logic [7:0]   inmediate_in;
  logic         valid_out;
  logic         wb_en;
  logic [W-1:0] mem_out;
  logic [W-1:0] data_out;
  logic [2:0]   dir_dest_out;
  logic [7:0]   inmediate_out;
  logic [3:0]   beat_idx;
  logic         last_out;

  beat_t        exp_q[$];
  logic [W-1:0] mdl_mem [256];
  int           n_checks;
  int           n_fail;

  etapa_mem_vec dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .vec_op        (vec_op),
    .vlen          (vlen),
    .addr_in       (addr_in),
    .data_in       (data_in),
    .result_alu    (result_alu),
    .sel_data      (sel_data),
    .dir_dest_in   (dir_dest_in),
    .inmediate_in  (inmediate_in),
    .valid_out     (valid_out),
    .wb_en         (wb_en),
    .mem_out       (mem_out),
    .data_out      (data_out),
    .dir_dest_out  (dir_dest_out),
    .inmediate_out (inmediate_out),
    .beat_idx      (beat_idx),
    .last_out      (last_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one op, one beat per cycle; expected beats come from the row model
  task automatic op(input logic rd, input logic wr, input logic vec, input logic [3:0] vl,
                    input logic [7:0] addr, input logic [31:0] seed, input logic sel,
                    input logic [W-1:0] alu, input logic [2:0] dest, input logic [7:0] imm);
    int eff;
    logic [7:0] row;
    logic [W-1:0] d;
    beat_t e;
    if (!vec || (!rd && !wr)) eff = 1;
    else if (vl == 0) eff = 1;
    else if (vl > 8) eff = 8;
    else eff = int'(vl);
    for (int k = 0; k < eff; k++) begin
      row = addr + 8'(k);
      d = {4{seed + 32'(k)}};
      valid_in = (k == 0);
      mem_rd = rd;
      mem_wr = wr;
      vec_op = vec;
      vlen = vl;
      addr_in = addr;
      data_in = d;
      result_alu = alu;
      sel_data = sel;
      dir_dest_in = dest;
      inmediate_in = imm;
      chk((k == 0) ? "ready_idle" : "ready_busy", ready_out, (k == 0));
      e.mem = (rd && !wr) ? mdl_mem[row] : '0;
      e.data = sel ? e.mem : alu;
      e.wb = !wr;
      e.idx = 4'(k);
      e.last = (k == eff - 1);
      e.dest = dest;
      e.imm = imm;
      exp_q.push_back(e);
      if (wr) mdl_mem[row] = d;
      @(negedge clk);
    end
    valid_in = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, valid_out, 1'b0);
    chk({tag, "_ready"}, ready_out, 1'b1);
    chk({tag, "_data"}, data_out, '0);
    chk({tag, "_mem"}, mem_out, '0);
    chk({tag, "_wb"}, wb_en, 1'b0);
    chk({tag, "_last"}, last_out, 1'b0);
    chk({tag, "_idx"}, beat_idx, 4'd0);
  endtask

  // scoreboard: every output beat must match the oldest expected beat
  always @(negedge clk) begin
    beat_t obs_b;
    beat_t exp_b;
    if (valid_out === 1'b1) begin
      chk("beat_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        obs_b = {data_out, mem_out, wb_en, beat_idx, last_out, dir_dest_out, inmediate_out};
        chk("wb_beat", obs_b, exp_b);
      end
    end
  end

  initial begin
    beat_t e;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    valid_in = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    vec_op = 1'b0;
    vlen = '0;
    addr_in = '0;
    data_in = '0;
    result_alu = '0;
    sel_data = 1'b0;
    dir_dest_in = '0;
    inmediate_in = '0;

    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // scalar store then scalar load of row 5
    op(1'b0, 1'b1, 1'b0, 4'd0, 8'd5, 32'h1111_1111, 1'b0, '0, 3'd1, 8'h12);
    op(1'b1, 1'b0, 1'b0, 4'd0, 8'd5, 32'h0, 1'b1, '0, 3'd2, 8'h34);
    idle_cycles(2);
    chk("scalar_load_data", data_out, {4{32'h1111_1111}});

    // vector store k per beat at row 10, then vector load back
    op(1'b0, 1'b1, 1'b1, 4'd4, 8'd10, 32'h0, 1'b0, '0, 3'd3, 8'h56);
    op(1'b1, 1'b0, 1'b1, 4'd4, 8'd10, 32'h0, 1'b1, '0, 3'd4, 8'h78);
    idle_cycles(2);
    chk("vec_load_last_data", data_out, {4{32'd3}});

    // wrap-around with clamp: vlen 15 becomes 8 rows 254..5
    op(1'b0, 1'b1, 1'b1, 4'd15, 8'd254, 32'hA000_0000, 1'b0, {4{32'hCAFE_0001}}, 3'd5, 8'h9A);
    op(1'b1, 1'b0, 1'b1, 4'd8, 8'd254, 32'h0, 1'b1, '0, 3'd6, 8'hBC);
    idle_cycles(2);

    // vlen 0 vector load is a single beat
    op(1'b1, 1'b0, 1'b1, 4'd0, 8'd11, 32'h0, 1'b1, '0, 3'd7, 8'hDE);
    // non-memory op selects the ALU result even with vec_op set
    op(1'b0, 1'b0, 1'b1, 4'd5, 8'd0, 32'h0, 1'b0, {4{32'hDEAD_BEEF}}, 3'd1, 8'h01);
    idle_cycles(1);
    chk("alu_data", data_out, {4{32'hDEAD_BEEF}});
    chk("alu_mem", mem_out, '0);
    // read+write together behaves as a store
    op(1'b1, 1'b1, 1'b0, 4'd0, 8'd20, 32'h5A5A_0000, 1'b1, '0, 3'd2, 8'h02);
    op(1'b1, 1'b0, 1'b0, 4'd0, 8'd20, 32'h0, 1'b1, '0, 3'd3, 8'h03);
    idle_cycles(2);

    // back-to-back scalar loads, one write-back pulse per cycle
    op(1'b1, 1'b0, 1'b0, 4'd0, 8'd5, 32'h0, 1'b1, '0, 3'd1, 8'h10);
    chk("tput_valid0", valid_out, 1'b1);
    op(1'b1, 1'b0, 1'b0, 4'd0, 8'd10, 32'h0, 1'b1, '0, 3'd2, 8'h11);
    chk("tput_valid1", valid_out, 1'b1);
    op(1'b1, 1'b0, 1'b0, 4'd0, 8'd11, 32'h0, 1'b1, '0, 3'd3, 8'h12);
    chk("tput_valid2", valid_out, 1'b1);
    op(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 32'h0, 1'b0, {4{32'h0000_0042}}, 3'd4, 8'h13);
    chk("tput_valid3", valid_out, 1'b1);
    op(1'b1, 1'b0, 1'b0, 4'd0, 8'd255, 32'h0, 1'b1, '0, 3'd5, 8'h14);
    chk("tput_valid4", valid_out, 1'b1);
    idle_cycles(2);

    // reset in the middle of a vlen-4 load at row 10: only beats 0 and 1 come out
    valid_in = 1'b1;
    mem_rd = 1'b1;
    mem_wr = 1'b0;
    vec_op = 1'b1;
    vlen = 4'd4;
    addr_in = 8'd10;
    sel_data = 1'b1;
    result_alu = '0;
    dir_dest_in = 3'd6;
    inmediate_in = 8'h77;
    for (int k = 0; k < 2; k++) begin
      e.mem = mdl_mem[8'd10 + 8'(k)];
      e.data = e.mem;
      e.wb = 1'b1;
      e.idx = 4'(k);
      e.last = 1'b0;
      e.dest = 3'd6;
      e.imm = 8'h77;
      exp_q.push_back(e);
      @(negedge clk);
      valid_in = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_ready_after", ready_out, 1'b1);
    idle_cycles(6);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
